// File: rtl/delay_sched_pkg.sv
// Shared types and default widths for the delay_match_scheduler slice.
package delay_sched_pkg;

    localparam int DEF_NUM_SLOTS = 4;
    localparam int DEF_DELAY_W   = 4;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic {
        IDLE,
        WAIT
    } slot_state_e;

    typedef enum logic [1:0] {
        NONE,
        MATCH,
        MISS
    } result_e;

endpackage

// File: rtl/delay_slot.sv
// One tracker slot: IDLE/WAIT state plus a down-counter loaded from dly on allocation.
module delay_slot
    import delay_sched_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc,
    input  logic [DELAY_W-1:0] dly,
    output logic               active,
    output logic               expiring
);

    slot_state_e        state, state_nx;
    logic [DELAY_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Allocation wins over expiry so a slot can be reused in its expiry cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (alloc) begin
            state_nx = WAIT;
            cnt_nx   = dly;
        end else if (state == WAIT) begin
            cnt_nx = cnt - DELAY_W'(1);
            if (cnt == DELAY_W'(1)) begin
                state_nx = IDLE;
            end
        end
    end

    always_comb begin
        active   = (state == WAIT);
        expiring = (state == WAIT) && (cnt == DELAY_W'(1));
    end

endmodule

// File: rtl/delay_match_scheduler.sv
// Multi-attempt a ##d b checker sharing a pool of tracker slots.
// Optional statistics counters are built when DELAY_SCHED_STATS_EN is defined.
module delay_match_scheduler
    import delay_sched_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int DELAY_W   = DEF_DELAY_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DELAY_W-1:0]             cfg_delay,
    input  logic                           cfg_load,
    input  logic                           a,
    input  logic                           b,
    output logic                           match,
    output logic                           miss,
    output logic                           overflow,
    output logic                           busy,
    output logic [$clog2(NUM_SLOTS+1)-1:0] active_count,
    output logic [CNT_W-1:0]               match_count,
    output logic [CNT_W-1:0]               miss_count
);

    localparam int ACT_W = $clog2(NUM_SLOTS + 1);

    logic [DELAY_W-1:0]   dly;
    logic [NUM_SLOTS-1:0] slot_active;
    logic [NUM_SLOTS-1:0] slot_expiring;
    logic [NUM_SLOTS-1:0] alloc;
    logic                 free_found;
    result_e              result_d, result_q;
    logic                 overflow_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        delay_slot #(.DELAY_W(DELAY_W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .alloc    (alloc[g]),
            .dly      (dly),
            .active   (slot_active[g]),
            .expiring (slot_expiring[g])
        );
    end

    // Delay is frozen while any attempt is in flight, which keeps expiries one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly <= DELAY_W'(1);
        end else if (cfg_load && !busy) begin
            dly <= (cfg_delay == '0) ? DELAY_W'(1) : cfg_delay;
        end
    end

    always_comb begin
        alloc      = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!free_found && (!slot_active[i] || slot_expiring[i])) begin
                free_found = 1'b1;
                alloc[i]   = a;
            end
        end
    end

    always_comb begin
        result_d = NONE;
        if (|slot_expiring) begin
            result_d = b ? MATCH : MISS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= NONE;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= a && !free_found;
        end
    end

    always_comb begin
        active_count = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            active_count = active_count + ACT_W'(slot_active[i]);
        end
    end

    assign busy     = (active_count != '0);
    assign match    = (result_q == MATCH);
    assign miss     = (result_q == MISS);
    assign overflow = overflow_q;

`ifdef DELAY_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
            miss_count  <= '0;
        end else begin
            if (match && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
            if (miss && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end
`else
    assign match_count = '0;
    assign miss_count  = '0;
`endif

endmodule

// File: tb/tb_delay_match_scheduler.sv
// Scoreboard bench for delay_match_scheduler: an attempt-list reference model predicts
// every match/miss/overflow pulse, slot occupancy and statistics counter value.
module tb_delay_match_scheduler;
    import delay_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cfg_delay = '0;
    logic          cfg_load = 1'b0;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          match, miss, overflow, busy;
    logic [2:0]    active_count;
    logic [CW-1:0] match_count, miss_count;

    delay_match_scheduler #(.NUM_SLOTS(N), .DELAY_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_delay    (cfg_delay),
        .cfg_load     (cfg_load),
        .a            (a),
        .b            (b),
        .match        (match),
        .miss         (miss),
        .overflow     (overflow),
        .busy         (busy),
        .active_count (active_count),
        .match_count  (match_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      cyc;
        result_e kind;
    } exp_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t res_q[$];
    int   ovf_q[$];
    int   pend[$];
    int   mdly = 1;
    int   act_cur = 0;
    int   act_next = 0;
    bit   mon_on = 1'b0;
    logic rst_last = 1'b0;
    logic [CW-1:0] mc = '0;
    logic [CW-1:0] xc = '0;

    int cds[3]     = '{7, 7, 0};
    int exp_lat[3] = '{9, 8, 2};

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and advance the reference model for that cycle.
    task automatic drive(input logic ai, input logic bi, input logic cl,
                         input logic [DW-1:0] cd, input logic r);
        int   occ;
        int   keep[$];
        exp_t e;
        @(posedge clk);
        #1;
        a = ai; b = bi; cfg_load = cl; cfg_delay = cd; rst = r;
        act_cur = act_next;
        if (r) begin
            pend.delete();
            while (res_q.size() > 0 && res_q[$].cyc > cyc) void'(res_q.pop_back());
            while (ovf_q.size() > 0 && ovf_q[$] > cyc) void'(ovf_q.pop_back());
            mdly = 1;
            act_next = 0;
        end else begin
            occ = 0;
            foreach (pend[i]) begin
                if (pend[i] == cyc) begin
                    e.cyc  = cyc + 1;
                    e.kind = bi ? MATCH : MISS;
                    res_q.push_back(e);
                end
                if (pend[i] > cyc) occ++;
            end
            if (ai) begin
                if (occ < N) pend.push_back(cyc + mdly);
                else         ovf_q.push_back(cyc + 1);
            end
            if (cl && act_cur == 0) mdly = (cd == '0) ? 1 : int'(cd);
            foreach (pend[i]) if (pend[i] > cyc) keep.push_back(pend[i]);
            pend = keep;
            act_next = pend.size();
        end
    endtask

    always @(negedge clk) begin
        logic          em, ex, eo;
        logic [2:0]    eact;
        logic [CW-1:0] emc, exc;
        exp_t          e;
        if (rst_last === 1'b1) begin
            mon_on = 1'b1;
            mc = '0;
            xc = '0;
        end
        if (mon_on) begin
            em = 1'b0; ex = 1'b0; eo = 1'b0;
            if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
                e  = res_q.pop_front();
                em = (e.kind == MATCH);
                ex = (e.kind == MISS);
            end
            if (ovf_q.size() > 0 && ovf_q[0] == cyc) begin
                void'(ovf_q.pop_front());
                eo = 1'b1;
            end
            eact = 3'(act_cur);
`ifdef DELAY_SCHED_STATS_EN
            emc = mc;
            exc = xc;
`else
            emc = '0;
            exc = '0;
`endif
            n_cmp += 7;
            if (match !== em) begin n_bad++; $display("FAIL sb_match cyc=%0d got=%b exp=%b", cyc, match, em); end
            if (miss !== ex) begin n_bad++; $display("FAIL sb_miss cyc=%0d got=%b exp=%b", cyc, miss, ex); end
            if (overflow !== eo) begin n_bad++; $display("FAIL sb_overflow cyc=%0d got=%b exp=%b", cyc, overflow, eo); end
            if (active_count !== eact) begin n_bad++; $display("FAIL sb_active cyc=%0d got=%0d exp=%0d", cyc, active_count, eact); end
            if (busy !== (eact != 0)) begin n_bad++; $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, busy, (eact != 0)); end
            if (match_count !== emc) begin n_bad++; $display("FAIL sb_match_count cyc=%0d got=%0d exp=%0d", cyc, match_count, emc); end
            if (miss_count !== exc) begin n_bad++; $display("FAIL sb_miss_count cyc=%0d got=%0d exp=%0d", cyc, miss_count, exc); end
            if (em && mc != '1) mc = mc + 1'b1;
            if (ex && xc != '1) xc = xc + 1'b1;
        end
        rst_last = rst;
    end

    task automatic test_reset();
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({match, miss, overflow, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0000", {match, miss, overflow, busy});
        end
        n_cmp++;
        if (active_count !== 3'd0) begin n_bad++; $display("FAIL reset_active got=%0d exp=0", active_count); end
        n_cmp++;
        if (match_count !== '0 || miss_count !== '0) begin
            n_bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", match_count, miss_count);
        end
    endtask

    task automatic test_single_match();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({match, miss, busy} !== 3'b100) begin
            n_bad++; $display("FAIL single_match got=%b exp=100 (match,miss,busy)", {match, miss, busy});
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_single_miss();
        drive(0, 0, 1, 3, 0);
        drive(1, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            if (k == 4) begin
                n_cmp++;
                if (miss !== 1'b1) begin n_bad++; $display("FAIL single_miss got=%b exp=1", miss); end
            end
`ifdef DELAY_SCHED_STATS_EN
            if (k == 5) begin
                n_cmp++;
                if (miss_count !== CW'(1)) begin n_bad++; $display("FAIL miss_count got=%0d exp=1", miss_count); end
            end
`endif
        end
    endtask

    task automatic test_overlap();
        int peak = 0, nm = 0, nx = 0;
        for (int k = 0; k <= 8; k++) begin
            drive(k <= 2, (k == 3) || (k == 5), 0, 0, 0);
            @(negedge clk);
            if (int'(active_count) > peak) peak = int'(active_count);
            if (match === 1'b1) nm++;
            if (miss === 1'b1) nx++;
        end
        n_cmp++;
        if (peak != 3) begin n_bad++; $display("FAIL overlap_peak got=%0d exp=3", peak); end
        n_cmp++;
        if (nm != 2 || nx != 1) begin n_bad++; $display("FAIL overlap_results got=%0d/%0d exp=2/1", nm, nx); end
    endtask

    task automatic test_overflow();
        int peak = 0, no = 0, nr = 0;
        drive(0, 0, 1, 8, 0);
        for (int k = 0; k < 20; k++) begin
            drive(k <= 5, 1'($urandom_range(0, 1)), 0, 0, 0);
            @(negedge clk);
            if (int'(active_count) > peak) peak = int'(active_count);
            if (overflow === 1'b1) no++;
            if (match === 1'b1 || miss === 1'b1) nr++;
        end
        n_cmp++;
        if (no != 2) begin n_bad++; $display("FAIL overflow_pulses got=%0d exp=2", no); end
        n_cmp++;
        if (peak != 4) begin n_bad++; $display("FAIL overflow_peak got=%0d exp=4", peak); end
        n_cmp++;
        if (nr != 4) begin n_bad++; $display("FAIL overflow_results got=%0d exp=4", nr); end
    endtask

    task automatic test_cfg_guard();
        int lat, k0;
        for (int s = 0; s < 3; s++) begin
            lat = 0;
            if (s == 0) begin
                drive(1, 0, 0, 0, 0);
                drive(0, 0, 1, DW'(cds[s]), 0);
                k0 = 2;
            end else begin
                drive(0, 0, 1, DW'(cds[s]), 0);
                drive(1, 0, 0, 0, 0);
                k0 = 1;
            end
            for (int k = k0; k <= 20; k++) begin
                drive(0, 0, 0, 0, 0);
                @(negedge clk);
                if (miss === 1'b1 && lat == 0) lat = k;
            end
            n_cmp++;
            if (lat != exp_lat[s]) begin
                n_bad++; $display("FAIL cfg_guard_%0d latency got=%0d exp=%0d", s, lat, exp_lat[s]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int nr = 0;
        drive(0, 0, 1, 5, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || active_count !== 3'd0) begin
            n_bad++; $display("FAIL midflight_reset got busy=%b active=%0d exp busy=0 active=0", busy, active_count);
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'(k % 2), 0, 0, 0);
            @(negedge clk);
            if (match === 1'b1 || miss === 1'b1) nr++;
        end
        n_cmp++;
        if (nr != 0) begin n_bad++; $display("FAIL midflight_discard got=%0d results exp=0", nr); end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 1, 2, 0);
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, DW'($urandom_range(0, 15)), 0);
        end
        for (int k = 0; k < 20; k++) drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (res_q.size() != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_drain got pending=%0d busy=%b exp 0/0", res_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_single_miss();
        test_overlap();
        test_overflow();
        test_cfg_guard();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/delay_match_scheduler.md
# delay_match_scheduler

Runtime-configurable checker for overlapping `a ##d b` attempts. Every cycle in which `a` is high opens a new attempt. Each attempt is assigned to one slot in a fixed pool of tracker slots, counted down for `d` cycles, and resolved as a match or a miss when `b` is sampled. The block sits beside the formal/cover property harness as the synthesizable, multi-attempt version of the single-attempt monitor FSMs. It is the block that shares the tracker resource between concurrent attempts.

## Interface
Parameters:
- `NUM_SLOTS`, default 4: number of concurrent attempts tracked; minimum 1.
- `DELAY_W`, default 4: width of the delay value.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cfg_delay`, input, `DELAY_W`: requested delay `d`.
- `cfg_load`, input, 1: latch `cfg_delay`; honoured only when `busy` is 0.
- `a`, input, 1: attempt start.
- `b`, input, 1: attempt completion condition.
- `match`, output, 1: one-cycle pulse, an attempt saw `b` at exactly `d` cycles.
- `miss`, output, 1: one-cycle pulse, an attempt saw `b` low at `d` cycles.
- `overflow`, output, 1: one-cycle pulse, `a` was dropped because all slots were busy.
- `busy`, output, 1: at least one slot is active.
- `active_count`, output, `$clog2(NUM_SLOTS+1)`: number of active slots.
- `match_count`, output, `CNT_W`: saturating count of matches.
- `miss_count`, output, `CNT_W`: saturating count of misses.

## Operation
- Delay register `dly` resets to 1.
- `cfg_load` with `busy` = 0 loads `cfg_delay`. A value of 0 is stored as 1.
- `cfg_load` with `busy` = 1 is ignored, and `dly` is unchanged.
- Each slot has two states, IDLE and WAIT, plus a down-counter `cnt` of width `DELAY_W`.
- IDLE to WAIT: the slot is the allocated slot and `a` = 1. `cnt` is loaded with `dly`.
- In WAIT, `cnt` decrements every cycle.
- WAIT with `cnt` == 1 is the expiry cycle:
  - `b` is sampled in that cycle.
  - The slot returns to IDLE at the next edge.
  - The result is registered: `match` if `b` = 1, `miss` if `b` = 0.
- Allocation picks the lowest-index slot that is IDLE or expiring this cycle. An expiring slot may be reused in the same cycle.
- If no slot qualifies and `a` = 1, the attempt is dropped and `overflow` pulses. Existing slots are unaffected.
- Attempts overlap freely: `a` on consecutive cycles occupies consecutive slots.
- `dly` cannot change while `busy` = 1, and at most one attempt starts per cycle. Therefore at most one slot expires per cycle, and `match`/`miss` are mutually exclusive single pulses.
- `active_count` equals the popcount of WAIT slots. `busy` = (`active_count` != 0).
- `rst` mid-operation: all slots go IDLE, and in-flight attempts are discarded with no `match`/`miss`.

## Timing
- Cycle numbering: `a` = 1 at cycle t; `b` is sampled at cycle t+dly.
- `match`/`miss` are asserted at cycle t+dly+1.
- `overflow` is asserted at cycle t+1.
- `active_count` reflects a new allocation from cycle t+1 onward.
- Reset values: `match`, `miss` and `overflow` are 0, `busy` is 0, `active_count` is 0, counters are 0, `dly` is 1.
- A sustained `a` with `NUM_SLOTS` >= `dly` never overflows. With `NUM_SLOTS` < `dly`, the first overflow occurs on the (`NUM_SLOTS`+1)-th consecutive `a`.

## Configuration
- Macro: `DELAY_SCHED_STATS_EN`.
- Defined:
  - `match_count` and `miss_count` increment on `match` and `miss` respectively, in the cycle after the pulse.
  - Both saturate at all-ones and clear on `rst`.
- Undefined:
  - No counter registers are built.
  - `match_count` and `miss_count` are tied to 0.
  - All other behaviour is identical.

## Structure
- Package `delay_sched_pkg` holds:
  - `slot_state_e` (IDLE, WAIT).
  - A `result_e` enum (NONE, MATCH, MISS).
  - Default width constants.
- Sub-module `delay_slot`:
  - One IDLE/WAIT state and down-counter.
  - Inputs: `alloc`, `dly`.
  - Outputs: `active`, `expiring`.
  - Instantiated `NUM_SLOTS` times.
- The top level contains:
  - The priority allocator.
  - Result and overflow registers.
  - The popcount.
  - The optional stats counters.

## Test plan
- **Single match:** `dly`=1, `a` at cycle 5, `b` at cycle 6 -> `match`=1 at cycle 7, `miss`=0, `busy` low at cycle 7.
- **Single miss:** `dly`=3, `a` at cycle 2, `b` low throughout -> `miss`=1 at cycle 6. With stats enabled, `miss_count`=1 at cycle 7.
- **Overlap:** `dly`=3, `NUM_SLOTS`=4, `a` at cycles 10, 11 and 12, `b` at cycles 13 and 15 only -> `match` at cycle 14, `miss` at cycle 15, `match` at cycle 16, `active_count` peaks at 3.
- **Overflow:** `dly`=8, `NUM_SLOTS`=4, `a` high for cycles 0 to 5 -> `overflow` pulses at cycles 5 and 6, `active_count` stays at 4, and exactly 4 results are reported later.
- **Config guard:** `cfg_load` with `cfg_delay`=7 while `busy`=1 -> `dly` unchanged. The same load when idle -> `dly`=7. `cfg_delay`=0 -> `dly`=1.
- **Reset mid-flight:** 2 slots active, `rst` pulsed for 1 cycle -> `busy`=0 and `active_count`=0 next cycle, with no `match` or `miss` ever emitted for the discarded attempts.
